dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the pipeline's MEM-stage interface. It services the load/store requests that the control unit encodes on mem_read/mem_write.
- Holds word-organised storage, performs byte/halfword lane selection and load extension, and adds a programmable access latency.
- While an access is in flight it asserts stall; the pipeline folds stall into its hazard freeze.

Parameters:
- ADDR_WIDTH, 10, word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, number of WAIT cycles per access; legal values 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  store data; the low byte or low halfword is used for sb/sh.
- mem_read  input  3  load encoding: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 illegal.
- mem_write  input  2  store encoding: 00 none, 01 sw, 10 sh, 11 sb.
- stall  output  1  high while a request is pending or in flight.
- rdata  output  32  extended load result; registered.
- done  output  1  one-cycle pulse at access completion.
- misalign  output  1  error flag for a misaligned or illegal request; valid while done=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; rdata, done and misalign go to 0; the pending request is discarded.
  - Storage contents are not cleared.
  - Reset mid-WAIT aborts the access with no memory write.
- req = (mem_read != 000) or (mem_write != 00).
- stall = req && state==IDLE, or state==WAIT. This is combinational; stall is 0 in DONE.
- FSM:
  - IDLE: if req, capture addr/wdata/encodings into request registers, load cnt = LATENCY-1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt==0, go to DONE and perform the access at this edge. Otherwise cnt decrements.
  - DONE: done=1, rdata/misalign valid; unconditionally return to IDLE.
- Timing: a request first seen in cycle 0 gives stall high for cycles 0..LATENCY and done in cycle LATENCY+1.
- The pipeline advances on the DONE edge and must withdraw or change the request by then. A request still present in the following IDLE cycle is treated as a new access.
- Inputs that change after capture are ignored.
- Addressing:
  - word index = mem_addr[ADDR_WIDTH+1:2]; higher address bits are ignored (aliasing).
  - Little-endian: byte lane n = bits 8n+7:8n; halfword at addr[1]=0 is bits 15:0, at addr[1]=1 is bits 31:16.
- Stores write only the addressed lanes (byte-enable style). Other lanes of the word are preserved.
- Loads:
  - lw returns the full word.
  - lh/lb are sign-extended from bit 15/7 of the selected field.
  - lhu/lbu are zero-extended.
  - Stores leave rdata unchanged.
- Error condition, any of:
  - lw/sw with addr[1:0] != 0;
  - lh/lhu/sh with addr[0] != 0;
  - mem_read = 110/111;
  - mem_read and mem_write both nonzero.
- On error: full latency still elapses, no write, rdata=0, misalign=1 in DONE.
- misalign and done return to 0 when leaving DONE.
- Read-after-write: a load following a store to the same word observes the stored data.

Test Plan:
- LATENCY=2: sw 0x12345678 to 0x10, then lw 0x10 -> stall high 3 cycles per access, done in cycle 3, rdata=0x12345678, misalign=0.
- After that word: sb 0xAB to 0x11, then lw 0x10 -> 0x1234AB78. Then lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB; lh 0x12 -> 0x00001234; lhu 0x10 -> 0x0000AB78.
- sh 0x8001 to 0x12, then lh 0x12 -> 0xFFFF8001. Then lw 0x10 -> 0x8001AB78 (lower halfword untouched).
- lw 0x13; sh 0x11; mem_read=110; mem_read=001 with mem_write=01 together -> each: done after full latency, misalign=1, rdata=0, memory unchanged on subsequent lw.
- sw 0xDEADBEEF to 0x20 with rst pulsed during WAIT -> stall drops the cycle after reset, done never pulses. A following lw 0x20 returns the prior contents.
- LATENCY=1: back-to-back lw 0x10, lw 0x14 held continuously -> stall pattern 1,1,0,1,1,0. done pulses in cycles 2 and 5 with the correct data. Address bits above ADDR_WIDTH+1 alias: lw 0x1010 (ADDR_WIDTH=10) returns the same data as lw 0x10.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the pipeline MEM stage. Services
//            lb/lbu/lh/lhu/lw and sb/sh/sw requests against word-organised
//            storage, adds a fixed access latency and flags misaligned or
//            illegal requests.
// Ports    : clk       - clock, all state changes on rising edge
//            rst       - synchronous active-high reset
//            mem_addr  - byte address of the request
//            mem_wdata - store data (low byte/halfword used for sb/sh)
//            mem_read  - load encoding (0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu)
//            mem_write - store encoding (0 none, 1 sw, 2 sh, 3 sb)
//            stall     - high while a request is pending or in flight
//            rdata     - registered, extended load result
//            done      - one-cycle completion pulse
//            misalign  - error flag, valid while done is high
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign
);

    localparam int          c_depth    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_rd;
    logic [1:0]            r_wr;
    logic [31:0]           r_rdata;
    logic                  r_done;
    logic                  r_mis;
    logic [31:0]           r_mem [c_depth];

    logic                  w_req;
    logic                  w_access;
    logic                  w_err;
    logic                  w_word_op;
    logic                  w_half_op;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_word;
    logic [31:0]           w_shift;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;
    logic [31:0]           w_load;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data;
    logic                  w_unused_addr;

    // Address bits above the storage range alias and are deliberately dropped.
    assign w_unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

    assign w_req = (mem_read != 3'b000) || (mem_write != 2'b00);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, stall and access strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_req;
                if (w_req) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = S_DONE;
                    w_access     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and latency counter. These need no reset: returning
    // to IDLE is enough to discard whatever they hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_addr  <= mem_addr[ADDR_WIDTH+1:0];
            r_wdata <= mem_wdata;
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_cnt   <= c_cnt_init;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Error decode on the captured request
    // ------------------------------------------------------------------
    always_comb begin
        w_word_op = (r_rd == 3'b001) || (r_wr == 2'b01);
        w_half_op = (r_rd == 3'b010) || (r_rd == 3'b011) || (r_wr == 2'b10);
        w_err     = (r_rd[2] && r_rd[1])
                 || ((r_rd != 3'b000) && (r_wr != 2'b00))
                 || (w_word_op && (r_addr[1:0] != 2'b00))
                 || (w_half_op && r_addr[0]);
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    assign w_idx   = r_addr[ADDR_WIDTH+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_rd)
            3'b001:  w_load = w_word;
            3'b010:  w_load = {{16{w_half[15]}}, w_half};
            3'b011:  w_load = {16'd0, w_half};
            3'b100:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b101:  w_load = {24'd0, w_byte};
            default: w_load = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store byte enables; data is replicated so every lane carries the
    // value and the enables alone decide what lands in storage.
    // ------------------------------------------------------------------
    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = r_wdata;
        case (r_wr)
            2'b01: begin
                w_be        = 4'b1111;
                w_lane_data = r_wdata;
            end
            2'b10: begin
                w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
            end
            2'b11: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_lane_data = {4{r_wdata[7:0]}};
            end
            default: begin
                w_be        = 4'b0000;
                w_lane_data = r_wdata;
            end
        endcase
    end

    // Storage is never cleared; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && w_access && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers: done/misalign are only high in the DONE cycle;
    // rdata holds its value across stores.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_done <= w_access;
            r_mis  <= w_access && w_err;
            if (w_access) begin
                if (w_err) begin
                    r_rdata <= 32'd0;
                end else if (r_rd != 3'b000) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign rdata    = r_rdata;
    assign done     = r_done;
    assign misalign = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Two instances
//            (LATENCY=2 and LATENCY=1) share one input stream; a byte-level
//            transaction model per instance predicts stall/done/misalign/
//            rdata every cycle, and directed steps pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int AW   = 10;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int NB   = 4 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic        stall0, done0, mis0;
    logic [31:0] rdata0;
    logic        stall1, done1, mis1;
    logic [31:0] rdata1;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .stall(stall0), .rdata(rdata0), .done(done0), .misalign(mis0)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .stall(stall1), .rdata(rdata1), .done(done1), .misalign(mis1)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction model state, one set per instance
    int          m_wait  [2];
    bit          m_done  [2];
    bit          m_mis   [2];
    logic [31:0] m_rdata [2];
    logic [31:0] c_addr  [2];
    logic [31:0] c_wd    [2];
    logic [2:0]  c_rd    [2];
    logic [1:0]  c_wr    [2];
    logic [7:0]  mb      [2][NB];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // Perform the captured access on the byte-array memory of instance i.
    function automatic void model_access(input int i);
        logic [31:0] a;
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [15:0] h;
        logic [7:0]  by;
        logic        bad;
        int          b;
        a  = c_addr[i];
        rd = c_rd[i];
        wr = c_wr[i];
        bad = (rd >= 3'd6) || (rd != 3'd0 && wr != 2'd0)
           || ((rd == 3'd1 || wr == 2'd1) && a[1:0] != 2'd0)
           || ((rd == 3'd2 || rd == 3'd3 || wr == 2'd2) && a[0]);
        if (bad) begin
            m_rdata[i] = 32'd0;
            m_mis[i]   = 1'b1;
            return;
        end
        m_mis[i] = 1'b0;
        b = int'(a[AW+1:0]);
        case (wr)
            2'd1: for (int k = 0; k < 4; k++) mb[i][b+k] = c_wd[i][8*k +: 8];
            2'd2: for (int k = 0; k < 2; k++) mb[i][b+k] = c_wd[i][8*k +: 8];
            2'd3: mb[i][b] = c_wd[i][7:0];
            default: ;
        endcase
        h  = {mb[i][b+1], mb[i][b]};
        by = mb[i][b];
        case (rd)
            3'd1: m_rdata[i] = {mb[i][b+3], mb[i][b+2], mb[i][b+1], mb[i][b]};
            3'd2: m_rdata[i] = {{16{h[15]}}, h};
            3'd3: m_rdata[i] = {16'd0, h};
            3'd4: m_rdata[i] = {{24{by[7]}}, by};
            3'd5: m_rdata[i] = {24'd0, by};
            default: ;
        endcase
    endfunction

    // Compare process: check every cycle, then advance the model across the
    // coming rising edge.
    always @(negedge clk) begin
        logic        req;
        logic        st, dn, ms, es;
        logic [31:0] rd;
        req = (mem_read != 3'd0) || (mem_write != 2'd0);
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? stall0 : stall1;
            dn = (i == 0) ? done0  : done1;
            ms = (i == 0) ? mis0   : mis1;
            rd = (i == 0) ? rdata0 : rdata1;
            es = (m_wait[i] > 0) || (!m_done[i] && req);
            chk($sformatf("stall[%0d]@%0t", i, $time), {31'd0, st}, {31'd0, es});
            chk($sformatf("done[%0d]@%0t", i, $time), {31'd0, dn}, {31'd0, m_done[i]});
            chk($sformatf("misalign[%0d]@%0t", i, $time), {31'd0, ms}, {31'd0, m_mis[i]});
            chk($sformatf("rdata[%0d]@%0t", i, $time), rd, m_rdata[i]);
            if (rst) begin
                m_wait[i]  = 0;
                m_done[i]  = 1'b0;
                m_mis[i]   = 1'b0;
                m_rdata[i] = 32'd0;
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
                m_mis[i]  = 1'b0;
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    model_access(i);
                    m_done[i] = 1'b1;
                end
            end else if (req) begin
                c_addr[i] = mem_addr;
                c_wd[i]   = mem_wdata;
                c_rd[i]   = mem_read;
                c_wr[i]   = mem_write;
                m_wait[i] = lat_of(i);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold a request for LAT0+1 cycles, withdraw it in the DONE cycle of the
    // slower instance and optionally pin its result to literal values.
    task automatic op(input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] rd, input logic [1:0] wr,
                      input bit lit, input logic [31:0] er, input logic em,
                      input string nm);
        mem_addr  = a;
        mem_wdata = wd;
        mem_read  = rd;
        mem_write = wr;
        repeat (LAT0 + 1) cyc();
        mem_read  = 3'd0;
        mem_write = 2'd0;
        @(negedge clk);
        if (lit) begin
            chk({nm, " done"}, {31'd0, done0}, 32'd1);
            chk({nm, " rdata"}, rdata0, er);
            chk({nm, " misalign"}, {31'd0, mis0}, {31'd0, em});
        end
        @(posedge clk);
        #1;
    endtask

    logic exp_s [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < 2; i++) begin
            m_wait[i]  = 0;
            m_done[i]  = 1'b0;
            m_mis[i]   = 1'b0;
            m_rdata[i] = 32'd0;
        end
        rst       = 1'b1;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_read  = 3'd0;
        mem_write = 2'd0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset stall", {31'd0, stall0}, 32'd0);
        chk("reset done", {31'd0, done0}, 32'd0);
        chk("reset rdata", rdata0, 32'd0);
        chk("reset misalign", {31'd0, mis0}, 32'd0);
        cyc();

        // Give every word in the exercised region known contents
        for (int w = 0; w < 16; w++) op(32'(w * 4), $urandom, 3'd0, 2'd1, 1'b0, 32'd0, 1'b0, "init");

        op(32'h10, 32'h12345678, 3'd0, 2'd1, 1'b0, 32'd0, 1'b0, "sw10");
        op(32'h10, 32'd0, 3'd1, 2'd0, 1'b1, 32'h12345678, 1'b0, "lw10");
        op(32'h11, 32'h000000AB, 3'd0, 2'd3, 1'b0, 32'd0, 1'b0, "sb11");
        op(32'h10, 32'd0, 3'd1, 2'd0, 1'b1, 32'h1234AB78, 1'b0, "lw10 after sb");
        op(32'h11, 32'd0, 3'd4, 2'd0, 1'b1, 32'hFFFFFFAB, 1'b0, "lb11");
        op(32'h11, 32'd0, 3'd5, 2'd0, 1'b1, 32'h000000AB, 1'b0, "lbu11");
        op(32'h12, 32'd0, 3'd2, 2'd0, 1'b1, 32'h00001234, 1'b0, "lh12");
        op(32'h10, 32'd0, 3'd3, 2'd0, 1'b1, 32'h0000AB78, 1'b0, "lhu10");
        op(32'h12, 32'h00008001, 3'd0, 2'd2, 1'b0, 32'd0, 1'b0, "sh12");
        op(32'h12, 32'd0, 3'd2, 2'd0, 1'b1, 32'hFFFF8001, 1'b0, "lh12 after sh");
        op(32'h10, 32'd0, 3'd1, 2'd0, 1'b1, 32'h8001AB78, 1'b0, "lw10 after sh");

        op(32'h13, 32'd0, 3'd1, 2'd0, 1'b1, 32'd0, 1'b1, "lw misaligned");
        op(32'h11, 32'hFFFFFFFF, 3'd0, 2'd2, 1'b1, 32'd0, 1'b1, "sh misaligned");
        op(32'h10, 32'd0, 3'd6, 2'd0, 1'b1, 32'd0, 1'b1, "illegal read");
        op(32'h10, 32'hFFFFFFFF, 3'd1, 2'd1, 1'b1, 32'd0, 1'b1, "read+write");
        op(32'h10, 32'd0, 3'd1, 2'd0, 1'b1, 32'h8001AB78, 1'b0, "lw10 unchanged");

        // Reset during WAIT aborts the store
        op(32'h20, 32'h0BADF00D, 3'd0, 2'd1, 1'b0, 32'd0, 1'b0, "sw20");
        mem_addr  = 32'h20;
        mem_wdata = 32'hDEADBEEF;
        mem_write = 2'd1;
        cyc();
        mem_write = 2'd0;
        rst       = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("stall after reset", {31'd0, stall0}, 32'd0);
        cyc();
        repeat (4) cyc();
        op(32'h20, 32'd0, 3'd1, 2'd0, 1'b1, 32'h0BADF00D, 1'b0, "lw20 after abort");
        op(32'h1010, 32'd0, 3'd1, 2'd0, 1'b1, 32'h8001AB78, 1'b0, "lw alias");

        // Back-to-back held loads on the LATENCY=1 instance
        op(32'h14, 32'hCAFEF00D, 3'd0, 2'd1, 1'b0, 32'd0, 1'b0, "sw14");
        for (int k = 0; k < 6; k++) begin
            mem_addr = (k < 3) ? 32'h10 : 32'h14;
            mem_read = 3'd1;
            @(negedge clk);
            chk($sformatf("lat1 stall c%0d", k), {31'd0, stall1}, {31'd0, exp_s[k]});
            chk($sformatf("lat1 done c%0d", k), {31'd0, done1}, {31'd0, exp_d[k]});
            if (k == 2) chk("lat1 rdata lw10", rdata1, 32'h8001AB78);
            if (k == 5) chk("lat1 rdata lw14", rdata1, 32'hCAFEF00D);
            @(posedge clk);
            #1;
        end
        mem_read = 3'd0;
        repeat (LAT0 + 4) cyc();

        // Randomized per-cycle stimulus inside the initialised region
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199, 0) == 0);
            if ($urandom_range(3, 0) == 0) begin
                a = $urandom & 32'hFFFFF03F;
                if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
                mem_addr  = a;
                mem_wdata = $urandom;
                sel = $urandom_range(9, 0);
                if (sel < 3) begin
                    mem_read  = 3'd0;
                    mem_write = 2'd0;
                end else if (sel < 6) begin
                    mem_read  = 3'($urandom_range(5, 1));
                    mem_write = 2'd0;
                end else if (sel < 9) begin
                    mem_read  = 3'd0;
                    mem_write = 2'($urandom_range(3, 1));
                end else begin
                    mem_read  = 3'($urandom_range(7, 0));
                    mem_write = 2'($urandom_range(3, 0));
                end
            end
            cyc();
        end
        rst       = 1'b0;
        mem_read  = 3'd0;
        mem_write = 2'd0;
        repeat (LAT0 + 4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
